iterative_mdu: RTL and testbench

Multi-cycle HI/LO multiply/divide unit for the MIPS core. It replaces the single-cycle multiplier, divider and HI/LO register pair. Operand width and bits-per-cycle are parametrised. A `busy` handshake lets the CPU stall on MFHI/MFLO or on a new multiply/divide while an operation is in flight. The block sits beside the ALU and is fed from the two register-file read ports.

---
 rtl/iterative_mdu.sv | 208 ++++++++++++++++++++
 tb/tb_iterative_mdu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_mdu.sv
// Multi-cycle MIPS HI/LO multiply/divide unit with a busy handshake for CPU stalls.
// Define ITERATIVE_MDU_ACCUMULATE_EN to add MADD/MADDU/MSUB/MSUBU (op 1xx).
module iterative_mdu #(
    parameter int unsigned Width         = 32,
    parameter int unsigned StepsPerCycle = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [Width-1:0] wData,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] high,
    output logic [Width-1:0] low
);
    localparam int unsigned Iters = Width / StepsPerCycle;
    localparam int unsigned CntW  = $clog2(Iters + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t           state;
    logic             fix_phase;
    logic [CntW-1:0]  count;
    logic [Width-1:0] work_hi;
    logic [Width-1:0] work_lo;
    logic [Width-1:0] opd;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;

    // Operand decode: signed ops become magnitudes plus sign flags.
    logic             signed_op;
    logic             div_op;
    logic             a_neg;
    logic             b_neg;
    logic             legal;
    logic [Width-1:0] a_mag;
    logic [Width-1:0] b_mag;

    always_comb begin
        signed_op = ~op[0];
        div_op    = ~op[2] & op[1];
        a_neg     = signed_op & a[Width-1];
        b_neg     = signed_op & b[Width-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
`ifdef ITERATIVE_MDU_ACCUMULATE_EN
        legal     = 1'b1;
`else
        legal     = ~op[2];
`endif
    end

    // StepsPerCycle iterations: shift-add multiply or restoring divide.
    logic [Width-1:0] step_hi;
    logic [Width-1:0] step_lo;
    logic [Width:0]   shifted;
    logic [Width-1:0] diff;
    logic [Width:0]   psum;

    always_comb begin
        step_hi = work_hi;
        step_lo = work_lo;
        shifted = '0;
        diff    = '0;
        psum    = '0;
        for (int unsigned i = 0; i < StepsPerCycle; i++) begin
            if (is_div) begin
                shifted = {step_hi, step_lo[Width-1]};
                diff    = shifted[Width-1:0] - opd;
                if (shifted >= {1'b0, opd}) begin
                    step_hi = diff;
                    step_lo = {step_lo[Width-2:0], 1'b1};
                end else begin
                    step_hi = shifted[Width-1:0];
                    step_lo = {step_lo[Width-2:0], 1'b0};
                end
            end else begin
                psum    = {1'b0, step_hi} + {1'b0, (step_lo[0] ? opd : {Width{1'b0}})};
                step_hi = psum[Width:1];
                step_lo = {psum[0], step_lo[Width-1:1]};
            end
        end
    end

    // Sign correction: product negates as a whole, quotient/remainder independently.
    logic [2*Width-1:0] work_full;
    logic [2*Width-1:0] fix_full;
    logic [2*Width-1:0] result_full;

    always_comb begin
        work_full = {work_hi, work_lo};
        if (is_div) begin
            fix_full = {(neg_hi ? -work_hi : work_hi), (neg_lo ? -work_lo : work_lo)};
        end else begin
            fix_full = neg_lo ? -work_full : work_full;
        end
    end

`ifdef ITERATIVE_MDU_ACCUMULATE_EN
    logic acc_op;
    logic sub_op;

    // Accumulate against HI/LO as they stand at the write edge.
    always_comb begin
        if (!acc_op) begin
            result_full = work_full;
        end else if (sub_op) begin
            result_full = {high, low} - work_full;
        end else begin
            result_full = {high, low} + work_full;
        end
    end
`else
    assign result_full = work_full;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fix_phase <= 1'b0;
            count     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            opd       <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            high      <= '0;
            low       <= '0;
`ifdef ITERATIVE_MDU_ACCUMULATE_EN
            acc_op    <= 1'b0;
            sub_op    <= 1'b0;
`endif
        end else if (!enable) begin
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (writeHi) high <= wData;
            if (writeLo) low  <= wData;
            unique case (state)
                IDLE: begin
                    if (start && legal) begin
                        busy      <= 1'b1;
                        count     <= CntW'(Iters);
                        fix_phase <= 1'b0;
                        is_div    <= div_op;
`ifdef ITERATIVE_MDU_ACCUMULATE_EN
                        acc_op    <= op[2];
                        sub_op    <= op[2] & op[1];
`endif
                        if (div_op && b == '0) begin
                            state   <= FIXUP;
                            work_hi <= a;
                            work_lo <= '1;
                            neg_hi  <= 1'b0;
                            neg_lo  <= 1'b0;
                        end else begin
                            state   <= RUN;
                            work_hi <= '0;
                            work_lo <= div_op ? a_mag : b_mag;
                            opd     <= div_op ? b_mag : a_mag;
                            neg_lo  <= a_neg ^ b_neg;
                            neg_hi  <= a_neg;
                        end
                    end
                end
                RUN: begin
                    if (writeHi || writeLo) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work_hi <= step_hi;
                        work_lo <= step_lo;
                        count   <= count - CntW'(1);
                        if (count == CntW'(1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (writeHi || writeLo) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        fix_phase <= 1'b0;
                    end else if (!fix_phase) begin
                        work_hi   <= fix_full[2*Width-1:Width];
                        work_lo   <= fix_full[Width-1:0];
                        fix_phase <= 1'b1;
                    end else begin
                        {high, low} <= result_full;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                        fix_phase   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_mdu.sv
// Directed scoreboard bench for iterative_mdu (32-bit, 1 and 2 steps per cycle).
module tb_iterative_mdu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        writeHi = 1'b0;
    logic        writeLo = 1'b0;
    logic [31:0] wData = '0;
    logic        busy, done, busy2, done2;
    logic [31:0] high, low, high2, low2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    iterative_mdu #(.Width(32), .StepsPerCycle(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .op(op),
        .a(a), .b(b), .writeHi(writeHi), .writeLo(writeLo), .wData(wData),
        .busy(busy), .done(done), .high(high), .low(low)
    );

    iterative_mdu #(.Width(32), .StepsPerCycle(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .start(start2), .op(op),
        .a(a), .b(b), .writeHi(writeHi), .writeLo(writeLo), .wData(wData),
        .busy(busy2), .done(done2), .high(high2), .low(low2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; optionally queue the expected result.
    task automatic start_op(input bit sel, input logic [2:0] o, input logic [31:0] aa,
                            input logic [31:0] bb, input bit push, input logic [31:0] ehi,
                            input logic [31:0] elo, input logic [31:0] elat);
        op = o;
        a  = aa;
        b  = bb;
        if (sel) start2 = 1'b1;
        else     start  = 1'b1;
        if (push) sb.push_back('{hi: ehi, lo: elo, lat: elat});
        tick();
        start     = 1'b0;
        start2    = 1'b0;
        start_cyc = cyc;
        check("busy after start", 64'(sel ? busy2 : busy), 64'd1);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        exp_t e;
        int   lat;
        logic d;
        d = sel ? done2 : done;
        for (int i = 0; i < 200 && !d; i++) begin
            tick();
            d = sel ? done2 : done;
        end
        lat = cyc - start_cyc;
        e   = sb.pop_front();
        check({tag, " done"}, 64'(d), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " hi/lo"}, sel ? {high2, low2} : {high, low}, {e.hi, e.lo});
        check({tag, " busy at done"}, 64'(sel ? busy2 : busy), 64'd0);
    endtask

    initial begin
        logic seen;
        enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi/lo", {high, low}, 64'd0);
        reset = 1'b0;
        tick();

        start_op(0, 3'b000, 32'hFFFF_FFFE, 32'h3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 34);
        wait_done(0, "MULT -2*3");
        start_op(0, 3'b001, 32'hFFFF_FFFE, 32'h3, 1, 32'h2, 32'hFFFF_FFFA, 34);
        wait_done(0, "MULTU");
        start_op(0, 3'b010, 32'hFFFF_FFF9, 32'h2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        wait_done(0, "DIV -7/2");
        start_op(0, 3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 34);
        wait_done(0, "DIVU 100/7");
        start_op(0, 3'b011, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFF_FFFF, 2);
        wait_done(0, "DIVU by zero");
        start_op(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 34);
        wait_done(0, "DIV MIN/-1");
        start_op(0, 3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 1, 32'h0, 32'd35, 34);
        wait_done(0, "MULT -5*-7");
        start_op(0, 3'b010, 32'd7, 32'hFFFF_FFFE, 1, 32'h1, 32'hFFFF_FFFD, 34);
        wait_done(0, "DIV 7/-2");
        start_op(1, 3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 18);
        wait_done(1, "DIVU x2 steps");

        // Second start while busy, with new operands, must not disturb the first.
        start_op(0, 3'b001, 32'd3, 32'd5, 1, 32'h0, 32'd15, 34);
        repeat (4) tick();
        op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, "start ignored while busy");

        // Enable held low for three edges stretches latency by three.
        start_op(0, 3'b000, 32'h1234, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_C964, 37);
        repeat (9) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        wait_done(0, "enable freeze");

        // MTLO mid-operation aborts without a done pulse.
        start_op(0, 3'b000, 32'd7, 32'd9, 0, '0, '0, 0);
        repeat (9) tick();
        writeLo = 1'b1; wData = 32'hAA;
        tick();
        writeLo = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi/lo", {high, low}, {32'hFFFF_FFFF, 32'h0000_00AA});
        seen = 1'b0;
        repeat (40) begin tick(); seen |= done; end
        check("abort no late done", 64'(seen), 64'd0);

        writeHi = 1'b1; writeLo = 1'b1; wData = 32'h5A5A_5A5A;
        tick();
        writeHi = 1'b0; writeLo = 1'b0;
        check("MTHI+MTLO idle", {high, low}, {32'h5A5A_5A5A, 32'h5A5A_5A5A});

`ifdef ITERATIVE_MDU_ACCUMULATE_EN
        writeHi = 1'b1; wData = 32'h0;
        tick();
        writeHi = 1'b0; writeLo = 1'b1; wData = 32'hFFFF_FFFF;
        tick();
        writeLo = 1'b0;
        start_op(0, 3'b101, 32'd1, 32'd1, 1, 32'h1, 32'h0, 34);
        wait_done(0, "MADDU 1*1");
        start_op(0, 3'b110, 32'd1, 32'd1, 1, 32'h0, 32'hFFFF_FFFF, 34);
        wait_done(0, "MSUB 1*1");
`else
        op = 3'b100; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("illegal op busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin tick(); seen |= done | busy; end
        check("illegal op no activity", 64'(seen), 64'd0);
        check("illegal op hi/lo", {high, low}, {32'h5A5A_5A5A, 32'h5A5A_5A5A});
`endif

        // Asynchronous reset in the middle of a divide.
        start_op(0, 3'b010, 32'd1000, 32'd3, 0, '0, '0, 0);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset done", 64'(done), 64'd0);
        check("mid-op reset hi/lo", {high, low}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post reset idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
